mux2_1: RTL and testbench

- Bit-sliced 2:1 multiplexer used as the B-operand selector in the ALU full-adder slice (sel=1 selects inverted B for subtraction).
- Provides a zero-latency combinational output `out` for the adder datapath.
- Also provides an optional one-cycle registered copy (`out_q`) with valid flag for pipelined ALU variants.
- Combinational path is built structurally per bit from not/and/or primitives, in gate-level style consistent with the ALU.

---
 rtl/mux2_1.sv | 68 ++++++
 tb/tb_mux2_1.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mux2_1.sv
// Bit-sliced 2:1 selector for the ALU B-operand path: gate-level combinational
// output plus an optional one-cycle registered copy with valid and select-change flags.
module mux2_1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             valid_q,
    output logic             sel_chg_q
);

    logic             sel_n_s;
    logic [WIDTH-1:0] and0_s;
    logic [WIDTH-1:0] and1_s;

    logic [WIDTH-1:0] out_d;
    logic             valid_d;
    logic             sel_chg_d;
    logic             last_sel_d;
    logic             last_sel_q;

    // One inverter on sel is shared by every bit slice.
    not u_sel_inv (sel_n_s, sel);

    for (genvar k = 0; k < WIDTH; k++) begin : g_slice
        and u_and0 (and0_s[k], i0[k], sel_n_s);
        and u_and1 (and1_s[k], i1[k], sel);
        or  u_or   (out[k], and0_s[k], and1_s[k]);
    end

    // Next-state for the capture stage; reset priority is applied in the flop block.
    always_comb begin
        out_d      = out_q;
        valid_d    = valid_q;
        sel_chg_d  = 1'b0;
        last_sel_d = last_sel_q;
        if (en) begin
            out_d      = out;
            valid_d    = 1'b1;
            sel_chg_d  = (sel != last_sel_q) & valid_q;
            last_sel_d = sel;
        end else begin
            sel_chg_d  = 1'b0;
        end
    end

    // Capture registers with synchronous reset overriding enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= {WIDTH{1'b0}};
            valid_q    <= 1'b0;
            sel_chg_q  <= 1'b0;
            last_sel_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            valid_q    <= valid_d;
            sel_chg_q  <= sel_chg_d;
            last_sel_q <= last_sel_d;
        end
    end

endmodule

// File: tb/tb_mux2_1.sv
// Directed self-checking bench for mux2_1: a WIDTH=1 instance for the
// combinational truth table and a WIDTH=8 instance for the registered stage.
module tb_mux2_1;

    logic       clk;
    logic       reset1, en1, sel1;
    logic [0:0] a0, a1, out1, out1_q;
    logic       valid1_q, chg1_q;

    logic       reset, en, sel;
    logic [7:0] i0, i1, out, out_q;
    logic       valid_q, sel_chg_q;

    int n_assert = 0;
    int n_fail   = 0;

    mux2_1 #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset1), .i0(a0), .i1(a1), .sel(sel1), .en(en1),
        .out(out1), .out_q(out1_q), .valid_q(valid1_q), .sel_chg_q(chg1_q)
    );

    mux2_1 #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .i0(i0), .i1(i1), .sel(sel), .en(en),
        .out(out), .out_q(out_q), .valid_q(valid_q), .sel_chg_q(sel_chg_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [7:0] q, input logic v, input logic c);
        chk({tag, "_out_q"}, {56'd0, out_q}, {56'd0, q});
        chk({tag, "_valid_q"}, {63'd0, valid_q}, {63'd0, v});
        chk({tag, "_sel_chg_q"}, {63'd0, sel_chg_q}, {63'd0, c});
    endtask

    initial begin
        reset1 = 1'b1; en1 = 1'b0; sel1 = 1'b0; a0 = 1'b0; a1 = 1'b0;
        reset  = 1'b1; en  = 1'b0; sel  = 1'b0; i0 = 8'h00; i1 = 8'h00;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_reg("reset_init", 8'h00, 1'b0, 1'b0);

        // WIDTH=1 truth table sweep, {i0,i1,sel}
        a0 = 1'b0; a1 = 1'b0; sel1 = 1'b0; #10 chk("tt_000", {63'd0, out1}, 64'd0);
        a0 = 1'b0; a1 = 1'b0; sel1 = 1'b1; #10 chk("tt_001", {63'd0, out1}, 64'd0);
        a0 = 1'b0; a1 = 1'b1; sel1 = 1'b0; #10 chk("tt_010", {63'd0, out1}, 64'd0);
        a0 = 1'b0; a1 = 1'b1; sel1 = 1'b1; #10 chk("tt_011", {63'd0, out1}, 64'd1);
        a0 = 1'b1; a1 = 1'b0; sel1 = 1'b0; #10 chk("tt_100", {63'd0, out1}, 64'd1);
        a0 = 1'b1; a1 = 1'b0; sel1 = 1'b1; #10 chk("tt_101", {63'd0, out1}, 64'd0);
        a0 = 1'b1; a1 = 1'b1; sel1 = 1'b0; #10 chk("tt_110", {63'd0, out1}, 64'd1);
        a0 = 1'b1; a1 = 1'b1; sel1 = 1'b1; #10 chk("tt_111", {63'd0, out1}, 64'd1);

        // Adder slice: i0=B, i1=~B
        a0 = 1'b0; a1 = 1'b1; sel1 = 1'b0; #10 chk("addB0_s0", {63'd0, out1}, 64'd0);
        a0 = 1'b0; a1 = 1'b1; sel1 = 1'b1; #10 chk("addB0_s1", {63'd0, out1}, 64'd1);
        a0 = 1'b1; a1 = 1'b0; sel1 = 1'b0; #10 chk("addB1_s0", {63'd0, out1}, 64'd1);
        a0 = 1'b1; a1 = 1'b0; sel1 = 1'b1; #10 chk("addB1_s1", {63'd0, out1}, 64'd0);

        // WIDTH=8 captures on consecutive edges
        @(negedge clk);
        reset = 1'b0; en = 1'b1; i0 = 8'hA5; i1 = 8'h3C; sel = 1'b0;
        #1 chk("comb_a5", {56'd0, out}, 64'hA5);
        @(negedge clk);
        chk_reg("cap1", 8'hA5, 1'b1, 1'b0);
        sel = 1'b1;
        #1 chk("comb_3c", {56'd0, out}, 64'h3C);
        @(negedge clk);
        chk_reg("cap2", 8'h3C, 1'b1, 1'b1);

        // Hold with en=0 while inputs move
        en = 1'b0; i0 = 8'h11; i1 = 8'h22; sel = 1'b0;
        #1 chk("hold1_comb", {56'd0, out}, 64'h11);
        @(negedge clk);
        chk_reg("hold1", 8'h3C, 1'b1, 1'b0);
        i0 = 8'h5A; i1 = 8'hC3; sel = 1'b1;
        #1 chk("hold2_comb", {56'd0, out}, 64'hC3);
        @(negedge clk);
        chk_reg("hold2", 8'h3C, 1'b1, 1'b0);
        i0 = 8'hFF; i1 = 8'h00; sel = 1'b0;
        #1 chk("hold3_comb", {56'd0, out}, 64'hFF);
        @(negedge clk);
        chk_reg("hold3", 8'h3C, 1'b1, 1'b0);

        // Mid-operation reset with en=1 for one cycle
        reset = 1'b1; en = 1'b1; i0 = 8'hA5; i1 = 8'h3C; sel = 1'b1;
        @(negedge clk);
        chk_reg("mid_reset", 8'h00, 1'b0, 1'b0);

        // First capture after reset with sel=1: no change pulse
        reset = 1'b0;
        @(negedge clk);
        chk_reg("first_after_rst", 8'h3C, 1'b1, 1'b0);
        sel = 1'b0;
        @(negedge clk);
        chk_reg("sel_to_0", 8'hA5, 1'b1, 1'b1);
        en = 1'b0; sel = 1'b1;
        @(negedge clk);
        chk_reg("pulse_end", 8'hA5, 1'b1, 1'b0);

        // Reset held with en=1: registers stay clear, out stays live
        reset = 1'b1; en = 1'b1; i0 = 8'h96; i1 = 8'h69; sel = 1'b1;
        @(negedge clk);
        chk_reg("rst_hold1", 8'h00, 1'b0, 1'b0);
        chk("rst_live1", {56'd0, out}, 64'h69);
        sel = 1'b0;
        @(negedge clk);
        chk_reg("rst_hold2", 8'h00, 1'b0, 1'b0);
        #1 chk("rst_live2", {56'd0, out}, 64'h96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
